// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word, opcode, control word and memory-stage state types
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       mem_indirect;
    logic       byte_access;
  } ctrl_struct;

  typedef enum logic {
    IDLE     = 1'b0,
    INDIRECT = 1'b1
  } lc3b_mem_state;

endpackage

// File: rtl/mem_byte_align.sv
// rtl/mem_byte_align.sv - byte lane selection, store replication, byte enables and LDB sign extension
import lc3b_types::*;

module mem_byte_align (
  input  lc3b_word   addr,
  input  logic       byte_access,
  input  lc3b_word   sr,
  input  lc3b_word   rdata,
  output lc3b_word   mem_addr,
  output logic [1:0] byte_enable,
  output lc3b_word   wdata,
  output lc3b_word   load_data
);

  logic [7:0] lane;

  always_comb begin
    lane        = 8'h00;
    mem_addr    = {addr[15:1], 1'b0};
    byte_enable = 2'b11;
    wdata       = sr;
    load_data   = rdata;
    if (byte_access) begin
      // Byte accesses keep the full address; bit 0 picks the high or low lane.
      mem_addr    = addr;
      byte_enable = addr[0] ? 2'b10 : 2'b01;
      wdata       = {sr[7:0], sr[7:0]};
      lane        = addr[0] ? rdata[15:8] : rdata[7:0];
      load_data   = {{8{lane[7]}}, lane};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LC-3b memory stage with MEM/WB register; LDI/STI indirection under MEM_STAGE_INDIRECT_EN
import lc3b_types::*;

module mem_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  ctrl_struct in_ctrl,
  input  lc3b_word   in_alu,
  input  lc3b_word   in_sr,
  input  lc3b_word   in_pc,
  input  lc3b_reg    in_dest,
  output logic       stall,
  output lc3b_word   dmem_address,
  output logic       dmem_read,
  output logic       dmem_write,
  output logic [1:0] dmem_byte_enable,
  output lc3b_word   dmem_wdata,
  input  logic       dmem_resp,
  input  lc3b_word   dmem_rdata,
  output logic       out_valid,
  output ctrl_struct out_ctrl,
  output lc3b_word   out_data,
  output lc3b_word   out_pc,
  output lc3b_reg    out_dest
);

  logic       mem_op;
  logic       final_access;
  logic       complete;
  lc3b_word   access_addr;
  logic       access_byte;
  logic       access_rd;
  logic       access_wr;
  lc3b_word   aligned_addr;
  lc3b_word   aligned_wdata;
  lc3b_word   load_data;
  logic [1:0] aligned_be;

`ifdef MEM_STAGE_INDIRECT_EN
  lc3b_mem_state state_q, state_d;
  lc3b_word      ptr_q, ptr_d;
`endif

  logic       out_valid_q, out_valid_d;
  ctrl_struct out_ctrl_q, out_ctrl_d;
  lc3b_word   out_data_q, out_data_d;
  lc3b_word   out_pc_q, out_pc_d;
  lc3b_reg    out_dest_q, out_dest_d;

  assign mem_op = in_valid & (in_ctrl.mem_read | in_ctrl.mem_write);

  always_comb begin
    access_addr  = in_alu;
    access_byte  = in_ctrl.byte_access;
    access_rd    = in_ctrl.mem_read;
    access_wr    = in_ctrl.mem_write;
    final_access = 1'b1;
`ifdef MEM_STAGE_INDIRECT_EN
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INDIRECT) begin
      access_addr = ptr_q;
      access_byte = 1'b0;
    end else if (in_ctrl.mem_indirect) begin
      // Pointer fetch: always a word read, whatever the final direction is.
      access_rd    = 1'b1;
      access_wr    = 1'b0;
      access_byte  = 1'b0;
      final_access = 1'b0;
    end
    if (!mem_op) begin
      state_d = IDLE;
    end else if (dmem_resp) begin
      if (final_access) begin
        state_d = IDLE;
      end else begin
        ptr_d   = dmem_rdata;
        state_d = INDIRECT;
      end
    end
`endif
  end

  mem_byte_align u_align (
    .addr        (access_addr),
    .byte_access (access_byte),
    .sr          (in_sr),
    .rdata       (dmem_rdata),
    .mem_addr    (aligned_addr),
    .byte_enable (aligned_be),
    .wdata       (aligned_wdata),
    .load_data   (load_data)
  );

  always_comb begin
    dmem_address     = '0;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = 2'b00;
    dmem_wdata       = '0;
    if (mem_op && !reset) begin
      dmem_address     = aligned_addr;
      dmem_read        = access_rd;
      dmem_write       = access_wr;
      dmem_byte_enable = aligned_be;
      dmem_wdata       = aligned_wdata;
    end
  end

  assign stall    = mem_op & ~reset & ~(final_access & dmem_resp);
  assign complete = in_valid & (~mem_op | (final_access & dmem_resp));

  // A stalled or absent instruction writes a bubble; payload fields hold.
  always_comb begin
    out_valid_d = complete;
    out_ctrl_d  = out_ctrl_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
    out_dest_d  = out_dest_q;
    if (complete) begin
      out_ctrl_d = in_ctrl;
      out_data_d = in_ctrl.mem_read ? load_data : in_alu;
      out_pc_d   = in_pc;
      out_dest_d = in_dest;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
      out_pc_q    <= '0;
      out_dest_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ctrl_q  <= out_ctrl_d;
      out_data_q  <= out_data_d;
      out_pc_q    <= out_pc_d;
      out_dest_q  <= out_dest_d;
    end
  end

`ifdef MEM_STAGE_INDIRECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_data  = out_data_q;
  assign out_pc    = out_pc_q;
  assign out_dest  = out_dest_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage (indirect tests under MEM_STAGE_INDIRECT_EN)
import lc3b_types::*;

module tb_mem_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid;
  ctrl_struct in_ctrl;
  lc3b_word   in_alu, in_sr, in_pc;
  lc3b_reg    in_dest;
  logic       stall;
  lc3b_word   dmem_address;
  logic       dmem_read, dmem_write;
  logic [1:0] dmem_byte_enable;
  lc3b_word   dmem_wdata;
  logic       dmem_resp;
  lc3b_word   dmem_rdata;
  logic       out_valid;
  ctrl_struct out_ctrl;
  lc3b_word   out_data, out_pc;
  lc3b_reg    out_dest;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_alu(in_alu), .in_sr(in_sr), .in_pc(in_pc), .in_dest(in_dest),
    .stall(stall), .dmem_address(dmem_address), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
    .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data),
    .out_pc(out_pc), .out_dest(out_dest)
  );

  always #5 clk = ~clk;

  function automatic ctrl_struct mk(lc3b_opcode op, logic rd, logic wr, logic ind, logic byt);
    ctrl_struct c;
    c              = '0;
    c.opcode       = op;
    c.load_regfile = ~wr;
    c.mem_read     = rd;
    c.mem_write    = wr;
    c.mem_indirect = ind;
    c.byte_access  = byt;
    return c;
  endfunction

  task automatic drive(input ctrl_struct c, input lc3b_word alu, input lc3b_word sr,
                       input lc3b_word pc, input lc3b_reg dest);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_alu   = alu;
    in_sr    = sr;
    in_pc    = pc;
    in_dest  = dest;
  endtask

  task automatic test_reset;
    drive(mk(op_ldr, 1, 0, 0, 0), 16'h3001, 16'h5555, 16'h0100, 3'd1);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h1111;
    #3;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin errors++; $display("FAIL reset_rw got %b%b exp 00", dmem_read, dmem_write); end
    checks++; if (dmem_address !== 16'h0000 || dmem_wdata !== 16'h0000 || dmem_byte_enable !== 2'b00) begin errors++; $display("FAIL reset_dmem got %h %h %b exp 0000 0000 00", dmem_address, dmem_wdata, dmem_byte_enable); end
    checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_pc !== 16'h0000 || out_dest !== 3'd0) begin errors++; $display("FAIL reset_out got %b %h %h %0d exp 0 0000 0000 0", out_valid, out_data, out_pc, out_dest); end
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    dmem_resp = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_alu;
    @(negedge clk);
    drive(mk(op_add, 0, 0, 0, 0), 16'h1234, 16'h0000, 16'h0300, 3'd2);
    dmem_resp = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", stall); end
    checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin errors++; $display("FAIL alu_rw got %b%b exp 00", dmem_read, dmem_write); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h1234) begin errors++; $display("FAIL alu_out got %b %h exp 1 1234", out_valid, out_data); end
    checks++; if (out_pc !== 16'h0300 || out_dest !== 3'd2 || out_ctrl.opcode !== op_add) begin errors++; $display("FAIL alu_copy got %h %0d %h exp 0300 2 1", out_pc, out_dest, out_ctrl.opcode); end
    dmem_resp = 1'b0;
  endtask

  task automatic test_ldr;
    @(negedge clk);
    drive(mk(op_ldr, 1, 0, 0, 0), 16'h3001, 16'h0000, 16'h0302, 3'd3);
    dmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (dmem_address !== 16'h3000 || stall !== 1'b1 || dmem_read !== 1'b1) begin errors++; $display("FAIL ldr_wait%0d got %h %b %b exp 3000 1 1", i, dmem_address, stall, dmem_read); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ldr_bubble%0d got %b exp 0", i, out_valid); end
    end
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'hBEEF;
    #1;
    checks++; if (stall !== 1'b0 || dmem_byte_enable !== 2'b11) begin errors++; $display("FAIL ldr_resp got %b %b exp 0 11", stall, dmem_byte_enable); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_dest !== 3'd3) begin errors++; $display("FAIL ldr_out got %b %h %0d exp 1 beef 3", out_valid, out_data, out_dest); end
  endtask

  task automatic test_byte;
    @(negedge clk);
    drive(mk(op_ldb, 1, 0, 0, 1), 16'h0041, 16'h0000, 16'h0304, 3'd4);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h80FF;
    #1;
    checks++; if (dmem_address !== 16'h0041 || dmem_byte_enable !== 2'b10 || stall !== 1'b0) begin errors++; $display("FAIL ldb_access got %h %b %b exp 0041 10 0", dmem_address, dmem_byte_enable, stall); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'hFF80) begin errors++; $display("FAIL ldb_out got %b %h exp 1 ff80", out_valid, out_data); end
    @(negedge clk);
    drive(mk(op_stb, 0, 1, 0, 1), 16'h0040, 16'h00AB, 16'h0306, 3'd0);
    #1;
    checks++; if (dmem_byte_enable !== 2'b01 || dmem_wdata !== 16'hABAB) begin errors++; $display("FAIL stb_lane got %b %h exp 01 abab", dmem_byte_enable, dmem_wdata); end
    checks++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_address !== 16'h0040) begin errors++; $display("FAIL stb_rw got %b%b %h exp 10 0040", dmem_write, dmem_read, dmem_address); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0040) begin errors++; $display("FAIL stb_out got %b %h exp 1 0040", out_valid, out_data); end
  endtask

  task automatic test_bubble;
    @(negedge clk);
    in_valid  = 1'b0;
    dmem_resp = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL bubble_idle%0d got %b%b %b exp 00 0", i, dmem_read, dmem_write, stall); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 16'h0040) begin errors++; $display("FAIL bubble_out%0d got %b %h exp 0 0040", i, out_valid, out_data); end
    end
    dmem_resp = 1'b0;
  endtask

`ifdef MEM_STAGE_INDIRECT_EN
  task automatic test_sti;
    @(negedge clk);
    drive(mk(op_sti, 0, 1, 1, 0), 16'h2000, 16'h1357, 16'h0308, 3'd0);
    dmem_resp = 1'b0;
    #1;
    checks++; if (dmem_address !== 16'h2000 || dmem_read !== 1'b1 || dmem_write !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL sti_ptr got %h %b%b %b exp 2000 10 1", dmem_address, dmem_read, dmem_write, stall); end
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h4000;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sti_ptr_resp got %b exp 1", stall); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sti_mid_valid got %b exp 0", out_valid); end
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    checks++; if (dmem_address !== 16'h4000 || dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_wdata !== 16'h1357 || stall !== 1'b1) begin errors++; $display("FAIL sti_write got %h %b%b %h %b exp 4000 01 1357 1", dmem_address, dmem_read, dmem_write, dmem_wdata, stall); end
    @(negedge clk);
    dmem_resp = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sti_done_stall got %b exp 0", stall); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 16'h0308) begin errors++; $display("FAIL sti_out got %b %h exp 1 0308", out_valid, out_pc); end
  endtask

  task automatic test_reset_indirect;
    @(negedge clk);
    drive(mk(op_sti, 0, 1, 1, 0), 16'h2000, 16'h2468, 16'h030A, 3'd0);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h4000;
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    checks++; if (dmem_address !== 16'h4000 || dmem_write !== 1'b1) begin errors++; $display("FAIL rsti_indirect got %h %b exp 4000 1", dmem_address, dmem_write); end
    reset = 1'b1;
    #1;
    checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || out_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL rsti_reset got %b%b %b %b exp 00 0 0", dmem_read, dmem_write, out_valid, stall); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (dmem_address !== 16'h2000 || dmem_read !== 1'b1 || dmem_write !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL rsti_restart got %h %b%b %b exp 2000 10 1", dmem_address, dmem_read, dmem_write, stall); end
    dmem_resp = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (dmem_address !== 16'h4000 || dmem_wdata !== 16'h2468 || stall !== 1'b0) begin errors++; $display("FAIL rsti_final got %h %h %b exp 4000 2468 0", dmem_address, dmem_wdata, stall); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rsti_out got %b exp 1", out_valid); end
    @(negedge clk);
    in_valid  = 1'b0;
    dmem_resp = 1'b0;
  endtask
`else
  task automatic test_ldi_direct;
    @(negedge clk);
    drive(mk(op_ldi, 1, 0, 1, 0), 16'h2000, 16'h0000, 16'h030C, 3'd5);
    dmem_resp = 1'b0;
    #1;
    checks++; if (dmem_address !== 16'h2000 || dmem_read !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL ldi_read got %h %b %b exp 2000 1 1", dmem_address, dmem_read, stall); end
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h4000;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ldi_single got %b exp 0", stall); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h4000 || out_dest !== 3'd5) begin errors++; $display("FAIL ldi_out got %b %h %0d exp 1 4000 5", out_valid, out_data, out_dest); end
    @(negedge clk);
    in_valid  = 1'b0;
    dmem_resp = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    in_valid   = 1'b0;
    in_ctrl    = '0;
    in_alu     = '0;
    in_sr      = '0;
    in_pc      = '0;
    in_dest    = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    test_reset;
    test_alu;
    test_ldr;
    test_byte;
    test_bubble;
`ifdef MEM_STAGE_INDIRECT_EN
    test_sti;
    test_reset_indirect;
`else
    test_ldi_direct;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
